// File: rtl/ac_link_pkg.sv
// rtl/ac_link_pkg.sv - shared types and constants for the PDP-8 AC/Link unit
//
// Package pdp8_pkg:
//   WORD_W / LW_W : width of AC and of the {L,AC} pair
//   OP_*          : bit positions of the group-1 microinstruction bits in op
//   state_t       : sequencer states
package pdp8_pkg;
    localparam int WORD_W = 12;
    localparam int LW_W   = 13;

    localparam int OP_CLA = 7;
    localparam int OP_CLL = 6;
    localparam int OP_CMA = 5;
    localparam int OP_CML = 4;
    localparam int OP_RAR = 3;
    localparam int OP_RAL = 2;
    localparam int OP_BSW = 1;
    localparam int OP_IAC = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4,
        P4B  = 3'd5,
        DONE = 3'd6
    } state_t;
endpackage

// File: rtl/ac_link_if.sv
// rtl/ac_link_if.sv - command/result bundle between the datapath and ac_link
//
// alu_s/alu_co : ALU result and carry
// ld_ac/clr_ac : load AC from ALU / clear AC
// start/op     : launch a group-1 microinstruction sequence
// ac/link      : accumulator and link outputs
// busy/done    : sequence in progress / one-cycle completion pulse
// master = command source, slave = ac_link.
interface ac_link_if;
    import pdp8_pkg::*;

    logic [WORD_W-1:0] alu_s;
    logic              alu_co;
    logic              ld_ac;
    logic              clr_ac;
    logic              start;
    logic [7:0]        op;
    logic [WORD_W-1:0] ac;
    logic              link;
    logic              busy;
    logic              done;

    modport master (
        output alu_s, alu_co, ld_ac, clr_ac, start, op,
        input  ac, link, busy, done
    );

    modport slave (
        input  alu_s, alu_co, ld_ac, clr_ac, start, op,
        output ac, link, busy, done
    );
endinterface

// File: rtl/ac_link_rotate.sv
// rtl/ac_link_rotate.sv - one rotate/byte-swap step on the 13-bit {L,AC}
//
// Module ac_rotate (combinational):
//   la     : {L,AC} input
//   rar    : rotate right one
//   ral    : rotate left one
//   bsw    : swap 6-bit halves of AC when neither rotate is set
//   la_out : {L,AC} after one step
module ac_rotate
    import pdp8_pkg::*;
(
    input  logic [LW_W-1:0] la,
    input  logic            rar,
    input  logic            ral,
    input  logic            bsw,
    output logic [LW_W-1:0] la_out
);
    always_comb begin
        la_out = la;
        case ({rar, ral})
            // L <= AC[11], AC <= {AC[10:0], L}
            2'b01: la_out = {la[11:0], la[12]};
            // L <= AC[0], AC <= {L, AC[11:1]}
            2'b10: la_out = {la[0], la[12:1]};
            2'b00: if (bsw) la_out = {la[12], la[5:0], la[11:6]};
            // Both rotates set cancel out, BSW included.
            default: la_out = la;
        endcase
    end
endmodule

// File: rtl/ac_link.sv
// rtl/ac_link.sv - PDP-8 accumulator/link registers and group-1 sequencer
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high; idle state, AC=0, L=0
//   bus   : ac_link_if.slave (ALU inputs, commands, ac/link/busy/done)
// Commands in IDLE/DONE take priority start > clr_ac > ld_ac. A started
// sequence walks P1..P4 (plus P4B for RTL/RTR), one phase per cycle.
module ac_link
    import pdp8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ac_link_if.slave   bus
);
    state_t            state, state_n;
    logic [7:0]        op_q, op_n;
    logic [WORD_W-1:0] ac_q, ac_n;
    logic              link_q, link_n;
    logic [LW_W-1:0]   rot_out;
    logic              double_rot;

    ac_rotate u_rotate (
        .la     ({link_q, ac_q}),
        .rar    (op_q[OP_RAR]),
        .ral    (op_q[OP_RAL]),
        .bsw    (op_q[OP_BSW]),
        .la_out (rot_out)
    );

    // RTL/RTR: BSW with exactly one rotate direction repeats the step.
    assign double_rot = op_q[OP_BSW] & (op_q[OP_RAR] ^ op_q[OP_RAL]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            ac_q   <= '0;
            link_q <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            ac_q   <= ac_n;
            link_q <= link_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        ac_n    = ac_q;
        link_n  = link_q;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    op_n    = bus.op;
                    state_n = P1;
                end else if (bus.clr_ac) begin
                    ac_n = '0;
                end else if (bus.ld_ac) begin
                    ac_n   = bus.alu_s;
                    link_n = link_q ^ bus.alu_co;
                end
            end
            P1: begin
                if (op_q[OP_CLA]) ac_n = '0;
                if (op_q[OP_CLL]) link_n = 1'b0;
                state_n = P2;
            end
            P2: begin
                if (op_q[OP_CMA]) ac_n = ~ac_q;
                if (op_q[OP_CML]) link_n = ~link_q;
                state_n = P3;
            end
            P3: begin
                // 13-bit increment: AC carry-out toggles L.
                if (op_q[OP_IAC]) {link_n, ac_n} = {link_q, ac_q} + 13'd1;
                state_n = P4;
            end
            P4: begin
                {link_n, ac_n} = rot_out;
                state_n = double_rot ? P4B : DONE;
            end
            P4B: begin
                {link_n, ac_n} = rot_out;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ac   = ac_q;
    assign bus.link = link_q;
    assign bus.busy = (state == P1) || (state == P2) || (state == P3) ||
                      (state == P4) || (state == P4B);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_ac_link.sv
// tb/tb_ac_link.sv - self-checking bench for ac_link
module tb_ac_link;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   overlap = 0;

    ac_link_if bus ();

    ac_link dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ac0;
        logic        l0;
        logic [7:0]  op;
        logic [11:0] ac1;
        logic        l1;
        int          nbusy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [11:0] v, input logic co);
        bus.ld_ac  = 1'b1;
        bus.alu_s  = v;
        bus.alu_co = co;
        @(negedge clk);
        bus.ld_ac  = 1'b0;
        bus.alu_co = 1'b0;
    endtask

    // Drive start for one edge, then scramble op to show it is latched.
    task automatic start_op(input logic [7:0] o);
        bus.start = 1'b1;
        bus.op    = o;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
    endtask

    // Count busy cycles until done, bounded.
    task automatic wait_done(output int nb, output bit got);
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        bit got;

        bus.alu_s  = '0;
        bus.alu_co = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.clr_ac = 1'b0;
        bus.start  = 1'b0;
        bus.op     = '0;

        //              ac0       l0    op            ac1       l1    nbusy
        vecs[0]  = '{12'o5555, 1'b1, 8'b11000001, 12'o0001, 1'b0, 4}; // CLA CLL IAC
        vecs[1]  = '{12'o7777, 1'b0, 8'b00000001, 12'o0000, 1'b1, 4}; // IAC wrap
        vecs[2]  = '{12'o0001, 1'b1, 8'b00000110, 12'o0006, 1'b0, 5}; // RTL
        vecs[3]  = '{12'o1234, 1'b0, 8'b00000010, 12'o3412, 1'b0, 4}; // BSW
        vecs[4]  = '{12'o1234, 1'b1, 8'b00100000, 12'o6543, 1'b1, 4}; // CMA
        vecs[5]  = '{12'o0000, 1'b0, 8'b00011000, 12'o4000, 1'b0, 4}; // CML RAR
        vecs[6]  = '{12'o2525, 1'b1, 8'b00001100, 12'o2525, 1'b1, 4}; // RAR RAL
        vecs[7]  = '{12'o0001, 1'b0, 8'b00001010, 12'o4000, 1'b0, 5}; // RTR
        vecs[8]  = '{12'o7070, 1'b0, 8'b00001110, 12'o7070, 1'b0, 4}; // RAR RAL BSW
        vecs[9]  = '{12'o1111, 1'b1, 8'b00000000, 12'o1111, 1'b1, 4}; // NOP
        vecs[10] = '{12'o0123, 1'b0, 8'b10100001, 12'o0000, 1'b1, 4}; // CLA CMA IAC

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_ac", int'(bus.ac), 0);
        check("reset_link", int'(bus.link), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);

        load(12'o7777, 1'b1);
        check("ld1_ac", int'(bus.ac), 'o7777);
        check("ld1_link", int'(bus.link), 1);
        load(12'o0012, 1'b1);
        check("ld2_ac", int'(bus.ac), 'o0012);
        check("ld2_link", int'(bus.link), 0);

        for (int v = 0; v < 11; v++) begin
            do_reset();
            load(vecs[v].ac0, vecs[v].l0);
            start_op(vecs[v].op);
            wait_done(nb, got);
            check($sformatf("vec%0d_done", v), int'(got), 1);
            check($sformatf("vec%0d_busy_cycles", v), nb, vecs[v].nbusy);
            check($sformatf("vec%0d_ac", v), int'(bus.ac), int'(vecs[v].ac1));
            check($sformatf("vec%0d_link", v), int'(bus.link), int'(vecs[v].l1));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", v), int'(bus.done), 0);
        end

        // Commands during busy are ignored.
        do_reset();
        load(12'o5555, 1'b1);
        start_op(8'b11000001);
        bus.start  = 1'b1;
        bus.op     = 8'b00000010;
        bus.ld_ac  = 1'b1;
        bus.alu_s  = 12'o7777;
        bus.alu_co = 1'b1;
        bus.clr_ac = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.alu_co = 1'b0;
        bus.clr_ac = 1'b0;
        wait_done(nb, got);
        check("busy_ign_done", int'(got), 1);
        check("busy_ign_cycles", nb + 1, 4);
        check("busy_ign_ac", int'(bus.ac), 'o0001);
        check("busy_ign_link", int'(bus.link), 0);

        // Back-to-back start accepted in DONE.
        start_op(8'b00000001);
        check("b2b_busy", int'(bus.busy), 1);
        check("b2b_done_low", int'(bus.done), 0);
        wait_done(nb, got);
        check("b2b_done", int'(got), 1);
        check("b2b_cycles", nb, 4);
        check("b2b_ac", int'(bus.ac), 'o0002);
        check("b2b_link", int'(bus.link), 0);

        // clr_ac beats ld_ac in IDLE; link untouched.
        do_reset();
        load(12'o3333, 1'b1);
        bus.clr_ac = 1'b1;
        bus.ld_ac  = 1'b1;
        bus.alu_s  = 12'o7777;
        bus.alu_co = 1'b1;
        @(negedge clk);
        bus.clr_ac = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.alu_co = 1'b0;
        check("clr_ld_ac", int'(bus.ac), 0);
        check("clr_ld_link", int'(bus.link), 1);

        // Asynchronous reset in P3.
        load(12'o4444, 1'b0);
        start_op(8'b00000001);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ac", int'(bus.ac), 0);
        check("arst_link", int'(bus.link), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b0;
        start_op(8'b00000001);
        wait_done(nb, got);
        check("post_rst_done", int'(got), 1);
        check("post_rst_cycles", nb, 4);
        check("post_rst_ac", int'(bus.ac), 'o0001);
        check("post_rst_link", int'(bus.link), 0);

        check("busy_done_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
